// File: rtl/pwm_duty_ramp_ctrl_if.sv
// ---------------------------------------------------------------------------
// pwm_duty_ramp_ctrl_if
// Bundle of the signals between the command/register logic and the duty
// ramp controller.
//   tgt_valid    requester -> ctrl   target request valid
//   tgt_ready    ctrl -> requester   controller can accept a target
//   tgt_duty     requester -> ctrl   requested final duty (WIDTH)
//   tgt_step     requester -> ctrl   max duty change per period, 0 means 1
//   hold         requester -> ctrl   freeze duty updates while high
//   duty_out     ctrl -> PWM         registered duty for the generator
//   period_start ctrl -> requester   high while the period counter is 0
//   busy         ctrl -> requester   ramp in progress
//   done         ctrl -> requester   one-cycle pulse, target reached
// master = requester side, slave = controller side.
// ---------------------------------------------------------------------------
interface pwm_duty_ramp_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_duty;
  logic [WIDTH-1:0] tgt_step;
  logic             hold;
  logic [WIDTH-1:0] duty_out;
  logic             period_start;
  logic             busy;
  logic             done;

  modport master (
    output tgt_valid, tgt_duty, tgt_step, hold,
    input  tgt_ready, duty_out, period_start, busy, done
  );

  modport slave (
    input  tgt_valid, tgt_duty, tgt_step, hold,
    output tgt_ready, duty_out, period_start, busy, done
  );
endinterface

// File: rtl/pwm_duty_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_duty_ramp_ctrl
// Ramps the PWM generator's duty toward a requested target by at most one
// step per PWM period. Owns the free-running period counter; duty_out only
// changes on the edge where the counter wraps to 0, so each period runs at a
// single duty.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  pwm_duty_ramp_ctrl_if.slave (handshake, hold, duty and status)
// ---------------------------------------------------------------------------
module pwm_duty_ramp_ctrl #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] DEFAULT_DUTY = '0
) (
  input logic                  clk,
  input logic                  rst,
  pwm_duty_ramp_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty;
  logic [WIDTH-1:0] tgt_r;
  logic [WIDTH-1:0] step_r;
  logic             done_r;
  logic             boundary;
  logic             accept;

  // Unsigned distance between two duties, one bit wider so it never wraps.
  function automatic logic [WIDTH:0] abs_diff(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    if (a > b) return {1'b0, a} - {1'b0, b};
    else       return {1'b0, b} - {1'b0, a};
  endfunction

  // A zero step would stall the ramp forever; treat it as one.
  function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] s);
    if (s == '0) return {{(WIDTH-1){1'b0}}, 1'b1};
    else         return s;
  endfunction

  // Edge on which cnt wraps 255 -> 0; the only edge duty may move on.
  assign boundary = (cnt == '1);
  assign accept   = bus.tgt_valid && (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      duty   <= DEFAULT_DUTY;
      state  <= IDLE;
      done_r <= 1'b0;
    end else begin
      cnt    <= cnt + 1'b1;
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          // The acceptance edge is never a ramp step, even on a boundary.
          if (accept) begin
            if (bus.tgt_duty == duty) done_r <= 1'b1;
            else                      state  <= RAMP;
          end
        end
        RAMP: begin
          if (boundary && !bus.hold) begin
            // Final step clamps to the target, so no overshoot or wrap.
            if (abs_diff(tgt_r, duty) <= {1'b0, step_r}) begin
              duty   <= tgt_r;
              done_r <= 1'b1;
              state  <= IDLE;
            end else if (tgt_r > duty) begin
              duty <= duty + step_r;
            end else begin
              duty <= duty - step_r;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Latched request: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      tgt_r  <= bus.tgt_duty;
      step_r <= sat_step(bus.tgt_step);
    end
  end

  assign bus.tgt_ready    = (state == IDLE);
  assign bus.busy         = (state == RAMP);
  assign bus.done         = done_r;
  assign bus.duty_out     = duty;
  assign bus.period_start = (cnt == '0);

endmodule
